ssd_word_sched: RTL and testbench
=================================

Name: ssd_word_sched

Overview:
- Time-shares the single four-digit seven-segment display between N_REQ independent word producers, such as the UART RX byte monitor, the VGA frame counter and debug status.
- Each producer posts 16-bit words at will. The scheduler buffers the latest word per producer.
- The displayed word is held for at least HOLD_CYCLES so that it is readable. Ownership is granted round-robin.
- Output WORD drives the WORD input of the seven-segment display driver directly.

Parameters:
- N_REQ, 4: number of requesters, 2..8.
- HOLD_W, 24: hold counter width.
- HOLD_CYCLES, 24'd5_000_000: minimum display time per grant, in CLK cycles (100 ms at 50 MHz). Legal range 1 .. 2^HOLD_W-1.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- REQ_VALID  in  N_REQ  bit i: requester i posts REQ_WORD slice i this cycle.
- REQ_WORD  in  16*N_REQ  slice i = bits [16i+15:16i].
- REQ_ACK  out  N_REQ  registered one-cycle pulse: word from requester i captured.
- FREEZE  in  1  pauses the hold counter and all grants; capture continues.
- WORD  out  16  word to display.
- OWNER  out  $clog2(N_REQ)  index of the current owner.
- OWNER_VALID  out  1  high once any word has been granted.

Behaviour:
- Reset, asynchronous, any state:
  - WORD=0, OWNER=0, OWNER_VALID=0, REQ_ACK=0.
  - All buffers=0, all pend flags=0, hold counter=0.
  - State=IDLE, last-granted pointer=N_REQ-1, so the first search starts at 0.
- Capture, every cycle, independent of FSM and FREEZE:
  - REQ_VALID[i] at edge t sets buf[i]=REQ_WORD slice i and pend[i]=1.
  - REQ_ACK[i]=1 during cycle t+1 only.
  - Back-to-back valids overwrite; only the latest word is kept. No backpressure.
- Round-robin pick: search pend starting at last+1, wrapping modulo N_REQ; the current owner is checked last.
- FSM states IDLE, HOLD, SCAN:
  - IDLE: WORD=0, OWNER_VALID=0. If any pend is set and FREEZE=0, grant the picked index k: WORD<=buf[k], OWNER<=k, last<=k, OWNER_VALID<=1, clear pend[k], counter<=0, go to HOLD.
  - HOLD: counter increments each cycle FREEZE=0 and holds while FREEZE=1. When counter==HOLD_CYCLES-1 and FREEZE=0, go to SCAN on the next edge.
  - SCAN: if any pend is set and FREEZE=0, grant as in IDLE and go to HOLD. Otherwise stay in SCAN; WORD and OWNER are unchanged and OWNER_VALID stays 1. IDLE is never re-entered except by reset.
- Latency: from IDLE, REQ_VALID at edge t gives pend at t, grant at edge t+1, WORD valid after t+1. That is 2 cycles from request to display.
- Simultaneous capture and grant on the same index k:
  - The grant uses the old buf[k].
  - The set wins: pend[k] stays 1 and the new word is queued.
- Same-owner regrant: if only the owner's pend is set in SCAN, it is regranted with the new word and the counter restarts.
- HOLD_CYCLES=1: HOLD lasts exactly 1 cycle.
- FREEZE held high: WORD and OWNER stay stable indefinitely. pend bits accumulate and ACKs still pulse. On release, counting or granting resumes from the frozen state.
- Reset mid-HOLD: everything returns to reset values and captured words are lost.
- Width rules:
  - Counter compare at HOLD_W bits.
  - The OWNER increment wraps via explicit compare to N_REQ-1, not by power-of-2 overflow.

Decomposition:
- Package ssd_pkg holds:
  - WORD_W=16;
  - typedef enum logic [1:0] {IDLE, HOLD, SCAN} ssd_sched_state_t;
  - function clog2_min1, which guarantees OWNER width ≥1.
- Sub-module ssd_rr_pick, purely combinational. Inputs: pend[N_REQ], last index. Outputs: any, pick index. It is reusable for other shared resources.

Test Plan (N_REQ=4, HOLD_CYCLES=4):
- Reset then single request: REQ_VALID=0001, word 16'h1234. REQ_ACK[0]=1 at t+1 only, WORD=16'h1234 / OWNER=0 / OWNER_VALID=1 from t+1. With no further requests, WORD stays stable.
- Round-robin: all four valid at once with words A0A0, B1B1, C2C2, D3D3. The display shows owners 0,1,2,3 in order, each exactly 5 cycles (4 HOLD cycles + 1 SCAN/grant edge).
- Overwrite: req2 posts 0x1111 then 0x2222 while req0 holds. The next grant to 2 shows 0x2222, and two ACK pulses are seen.
- Same-cycle capture and grant: req1 posts 0x5555 on the edge of its grant, with buf[1]=0x4444 already. 0x4444 is shown, then after the hold 0x5555 is regranted (OWNER=1).
- FREEZE: assert mid-HOLD for 20 cycles while req3 posts. WORD is unchanged for 20 cycles and REQ_ACK[3] pulses. After release the remaining hold completes, then req3 is granted.
- Async reset mid-HOLD: drop RST_N between edges. WORD=0 and OWNER_VALID=0 immediately, without waiting for a CLK edge. After release a new request is granted in 2 cycles.

Source files
------------

// File: rtl/ssd_word_sched_pkg.sv
// Shared types and helpers for the seven-segment word scheduler.
package ssd_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {IDLE, HOLD, SCAN} ssd_sched_state_t;

  // Index width that never collapses to zero bits for tiny requester counts.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ssd_rr_pick.sv
// Combinational round-robin picker: searches from last+1, wrapping, last index checked last.
module ssd_rr_pick
  import ssd_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = clog2_min1(N_REQ)
) (
  input  logic [N_REQ-1:0] i_pend,
  input  logic [IDX_W-1:0] i_last,
  output logic             o_any,
  output logic [IDX_W-1:0] o_pick
);

  logic [IDX_W-1:0] w_idx;

  always_comb begin
    o_any  = 1'b0;
    o_pick = '0;
    w_idx  = i_last;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      // Explicit wrap so non-power-of-two counts stay in range.
      w_idx = (w_idx == IDX_W'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
      if (!o_any && i_pend[w_idx]) begin
        o_any  = 1'b1;
        o_pick = w_idx;
      end
    end
  end

endmodule

// File: rtl/ssd_word_sched.sv
// Time-shares the seven-segment display between N_REQ word producers,
// holding each granted word for at least HOLD_CYCLES clocks.
module ssd_word_sched
  import ssd_pkg::*;
#(
  parameter int unsigned       N_REQ       = 4,
  parameter int unsigned       HOLD_W      = 24,
  parameter logic [HOLD_W-1:0] HOLD_CYCLES = 24'd5_000_000
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic [N_REQ-1:0]              REQ_VALID,
  input  logic [WORD_W*N_REQ-1:0]       REQ_WORD,
  output logic [N_REQ-1:0]              REQ_ACK,
  input  logic                          FREEZE,
  output logic [WORD_W-1:0]             WORD,
  output logic [clog2_min1(N_REQ)-1:0]  OWNER,
  output logic                          OWNER_VALID
);

  localparam int unsigned       IDX_W     = clog2_min1(N_REQ);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_CYCLES - 1'b1;

  ssd_sched_state_t  r_state, w_state_nxt;
  logic [WORD_W-1:0] r_buf [N_REQ];
  logic [N_REQ-1:0]  r_pend;
  logic [N_REQ-1:0]  r_ack;
  logic [HOLD_W-1:0] r_cnt;
  logic [IDX_W-1:0]  r_last;
  logic [IDX_W-1:0]  r_owner;
  logic [WORD_W-1:0] r_word;
  logic              r_owner_valid;

  logic              w_any;
  logic [IDX_W-1:0]  w_pick;
  logic              w_grant;
  logic [N_REQ-1:0]  w_clr;

  ssd_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_pend (r_pend),
    .i_last (r_last),
    .o_any  (w_any),
    .o_pick (w_pick)
  );

  // A capture on the granted index re-sets pend, so the new word stays queued.
  always_comb begin
    w_clr = '0;
    if (w_grant) w_clr[w_pick] = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned i = 0; i < N_REQ; i++) r_buf[i] <= '0;
      r_pend <= '0;
      r_ack  <= '0;
    end else begin
      r_ack  <= REQ_VALID;
      r_pend <= (r_pend & ~w_clr) | REQ_VALID;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (REQ_VALID[i]) r_buf[i] <= REQ_WORD[WORD_W*i +: WORD_W];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    case (r_state)
      IDLE, SCAN: begin
        if (w_any && !FREEZE) begin
          w_grant     = 1'b1;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (!FREEZE && (r_cnt == HOLD_LAST)) w_state_nxt = SCAN;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt         <= '0;
      r_last        <= IDX_W'(N_REQ - 1);
      r_word        <= '0;
      r_owner       <= '0;
      r_owner_valid <= 1'b0;
    end else if (w_grant) begin
      r_word        <= r_buf[w_pick];
      r_owner       <= w_pick;
      r_last        <= w_pick;
      r_owner_valid <= 1'b1;
      r_cnt         <= '0;
    end else if (r_state == HOLD && !FREEZE) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign REQ_ACK     = r_ack;
  assign WORD        = r_word;
  assign OWNER       = r_owner;
  assign OWNER_VALID = r_owner_valid;

endmodule

// File: tb/tb_ssd_word_sched.sv
// Scoreboard bench for ssd_word_sched (N_REQ=4, HOLD_CYCLES=4).
module tb_ssd_word_sched;
  import ssd_pkg::*;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic [3:0]  REQ_VALID = '0;
  logic [63:0] REQ_WORD = '0;
  logic        FREEZE = 1'b0;
  logic [3:0]  REQ_ACK;
  logic [15:0] WORD;
  logic [1:0]  OWNER;
  logic        OWNER_VALID;

  ssd_word_sched #(
    .N_REQ       (4),
    .HOLD_W      (24),
    .HOLD_CYCLES (24'd4)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .REQ_VALID   (REQ_VALID),
    .REQ_WORD    (REQ_WORD),
    .REQ_ACK     (REQ_ACK),
    .FREEZE      (FREEZE),
    .WORD        (WORD),
    .OWNER       (OWNER),
    .OWNER_VALID (OWNER_VALID)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  typedef struct {
    logic [1:0]  owner;
    logic [15:0] word;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad = 0;
  int          ack_cnt[4] = '{0, 0, 0, 0};
  logic [18:0] prev = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic exp_push(input logic [1:0] o, input logic [15:0] w, input int c);
    exp_t e;
    e.owner = o;
    e.word  = w;
    e.cyc   = c;
    sb.push_back(e);
  endtask

  task automatic set_req(input int i, input logic [15:0] w);
    REQ_VALID[i]       = 1'b1;
    REQ_WORD[16*i +: 16] = w;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    #1;
    chk("scoreboard_drain", sb.size(), 0);
  endtask

  // Monitor: every change of the displayed tuple must match the next expectation.
  always @(negedge CLK) begin
    for (int i = 0; i < 4; i++) if (REQ_ACK[i]) ack_cnt[i]++;
    if (!RST_N) begin
      prev = '0;
    end else if ({OWNER_VALID, OWNER, WORD} != prev) begin
      prev = {OWNER_VALID, OWNER, WORD};
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_display: got owner=%0d word=%h cyc=%0d, required no change",
                 OWNER, WORD, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (OWNER !== mon_e.owner || WORD !== mon_e.word || cyc != mon_e.cyc || OWNER_VALID !== 1'b1) begin
          bad++;
          $display("FAIL display: got owner=%0d word=%h cyc=%0d ov=%0b, required owner=%0d word=%h cyc=%0d ov=1",
                   OWNER, WORD, cyc, OWNER_VALID, mon_e.owner, mon_e.word, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin
    int base;
    int a2, a3, unstable;

    // Reset values
    #1 RST_N = 1'b0;
    #1;
    chk("rst_word", WORD, 0);
    chk("rst_owner", OWNER, 0);
    chk("rst_ov", OWNER_VALID, 0);
    chk("rst_ack", REQ_ACK, 0);
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    tick();

    // Single request: 2-cycle latency, one-cycle ACK
    base = cyc;
    set_req(0, 16'h1234);
    exp_push(2'd0, 16'h1234, base + 2);
    tick();
    REQ_VALID = '0;
    @(negedge CLK);
    chk("ack0_pulse", REQ_ACK, 4'b0001);
    chk("pre_grant_ov", OWNER_VALID, 0);
    @(negedge CLK);
    chk("ack0_off", REQ_ACK, 4'b0000);
    chk("post_grant_ov", OWNER_VALID, 1);
    repeat (20) @(posedge CLK);
    #1;
    chk("single_stable", WORD, 16'h1234);
    chk("single_queue", sb.size(), 0);

    // Round-robin from reset: owners 0..3, 5 cycles apart
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    tick();
    base = cyc;
    REQ_VALID = 4'hF;
    REQ_WORD  = {16'hD3D3, 16'hC2C2, 16'hB1B1, 16'hA0A0};
    exp_push(2'd0, 16'hA0A0, base + 2);
    exp_push(2'd1, 16'hB1B1, base + 7);
    exp_push(2'd2, 16'hC2C2, base + 12);
    exp_push(2'd3, 16'hD3D3, base + 17);
    tick();
    REQ_VALID = '0;
    wait_drain(40);
    repeat (6) @(posedge CLK);
    #1;

    // Overwrite: req2 posts twice while req0 holds
    base = cyc;
    a2 = ack_cnt[2];
    set_req(0, 16'h0F0F);
    exp_push(2'd0, 16'h0F0F, base + 2);
    tick();
    REQ_VALID = '0;
    tick();
    set_req(2, 16'h1111);
    tick();
    set_req(2, 16'h2222);
    tick();
    REQ_VALID = '0;
    exp_push(2'd2, 16'h2222, base + 7);
    wait_drain(20);
    chk("ack2_twice", ack_cnt[2] - a2, 2);
    repeat (6) @(posedge CLK);
    #1;

    // Capture on the grant edge: old word shown, new word regranted
    base = cyc;
    set_req(1, 16'h4444);
    tick();
    set_req(1, 16'h5555);
    tick();
    REQ_VALID = '0;
    exp_push(2'd1, 16'h4444, base + 2);
    exp_push(2'd1, 16'h5555, base + 7);
    repeat (7) @(posedge CLK);
    #1;

    // FREEZE two cycles into the 5555 hold, for 20 edges
    FREEZE = 1'b1;
    a3 = ack_cnt[3];
    unstable = 0;
    exp_push(2'd3, 16'h3333, base + 32);
    for (int k = 0; k < 20; k++) begin
      if (k == 4) set_req(3, 16'h3333);
      else        REQ_VALID = '0;
      @(negedge CLK);
      if (WORD !== 16'h5555 || OWNER !== 2'd1) unstable++;
      tick();
    end
    FREEZE = 1'b0;
    REQ_VALID = '0;
    chk("freeze_stable", unstable, 0);
    wait_drain(20);
    chk("ack3_during_freeze", ack_cnt[3] - a3, 1);

    // Async reset mid-HOLD discards the pending req0 word
    tick();
    set_req(0, 16'h9999);
    tick();
    REQ_VALID = '0;
    #2 RST_N = 1'b0;
    #1;
    chk("arst_word", WORD, 0);
    chk("arst_ov", OWNER_VALID, 0);
    chk("arst_owner", OWNER, 0);
    chk("arst_ack", REQ_ACK, 0);
    @(posedge CLK);
    #2 RST_N = 1'b1;
    tick();
    base = cyc;
    set_req(2, 16'h7777);
    exp_push(2'd2, 16'h7777, base + 2);
    tick();
    REQ_VALID = '0;
    wait_drain(10);
    repeat (10) @(posedge CLK);
    #1;
    chk("post_reset_word", WORD, 16'h7777);
    chk("final_queue", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
